seven_segment_reader: RTL and testbench

- Monitors a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and recovers the hex value being shown.
- Acts as the inverse of the team's hex-to-segment encoder.
- Used as an on-board self-check of display output and as the bench-side display monitor.
- Samples each digit after its pattern is stable, decodes it to a nibble, assembles a full frame and pulses valid once every digit has been captured.

---
 rtl/seven_segment_reader_if.sv | 24 ++
 rtl/seven_segment_reader.sv | 127 ++++++++++++
 tb/tb_seven_segment_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_reader_if.sv
// Display bus plus decoded-frame result bundle for the seven-segment reader.
// The master drives the display pins and enable; the slave (the reader) returns the frame.
interface seven_segment_reader_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     an_n;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     digit_err;
    logic                  error;
    logic                  valid;

    modport master (
        output enable, seg_n, an_n,
        input  value, blank, digit_err, error, valid
    );

    modport slave (
        input  enable, seg_n, an_n,
        output value, blank, digit_err, error, valid
    );
endinterface

// File: rtl/seven_segment_reader.sv
// Recovers the hex frame shown on a multiplexed active-low seven-segment display.
// state | meaning: COLLECT = gathering stable digit captures; PRESENT = one-cycle frame publish
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    seven_segment_reader_if.slave  bus
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t                state;
    logic [DIGITS-1:0]     s_an;
    logic [6:0]            s_seg;
    logic [RW-1:0]         run;
    logic [RW-1:0]         run_next;
    logic [4*DIGITS-1:0]   stg_val;
    logic [DIGITS-1:0]     stg_blank;
    logic [DIGITS-1:0]     stg_err;
    logic [DIGITS-1:0]     mask;
    logic [DIGITS-1:0]     cap_mask;
    logic                  legal;
    logic                  same;
    logic                  capture;
    logic [5:0]            dec;

    // Returns {err, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 6'h00;
            7'b1111001: decode = 6'h01;
            7'b0100100: decode = 6'h02;
            7'b0110000: decode = 6'h03;
            7'b0011001: decode = 6'h04;
            7'b0010010: decode = 6'h05;
            7'b0000010: decode = 6'h06;
            7'b1111000: decode = 6'h07;
            7'b0000000: decode = 6'h08;
            7'b0011000: decode = 6'h09;
            7'b0001000: decode = 6'h0A;
            7'b0000011: decode = 6'h0B;
            7'b1000110: decode = 6'h0C;
            7'b0100001: decode = 6'h0D;
            7'b0000110: decode = 6'h0E;
            7'b0001110: decode = 6'h0F;
            7'b1111111: decode = 6'b01_0000;
            default:    decode = 6'b10_0000;
        endcase
    endfunction

    // The run length describes the sample being registered this edge, so the
    // capture lands STABLE_CYCLES-1 edges after the pattern first appears in S.
    always_comb begin
        legal    = $onehot(~bus.an_n);
        same     = ({bus.an_n, bus.seg_n} == {s_an, s_seg});
        run_next = '0;
        if (legal) begin
            if (!same)               run_next = RW'(1);
            else if (run == RUN_MAX) run_next = run;
            else                     run_next = run + RW'(1);
        end
        capture  = legal && (run_next == RUN_MAX) && (run != RUN_MAX);
        cap_mask = capture ? ~bus.an_n : '0;
        dec      = decode(bus.seg_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COLLECT;
            s_an          <= '1;
            s_seg         <= '1;
            run           <= '0;
            stg_val       <= '0;
            stg_blank     <= '0;
            stg_err       <= '0;
            mask          <= '0;
            bus.value     <= '0;
            bus.blank     <= '0;
            bus.digit_err <= '0;
            bus.error     <= 1'b0;
            bus.valid     <= 1'b0;
        end else if (!bus.enable) begin
            state     <= COLLECT;
            s_an      <= '1;
            s_seg     <= '1;
            run       <= '0;
            mask      <= '0;
            bus.valid <= 1'b0;
        end else begin
            s_an      <= bus.an_n;
            s_seg     <= bus.seg_n;
            run       <= run_next;
            bus.valid <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                if (cap_mask[k]) begin
                    stg_val[4*k +: 4] <= dec[3:0];
                    stg_blank[k]      <= dec[4];
                    stg_err[k]        <= dec[5];
                end
            end
            case (state)
                COLLECT: begin
                    if (&mask) begin
                        state         <= PRESENT;
                        bus.value     <= stg_val;
                        bus.blank     <= stg_blank;
                        bus.digit_err <= stg_err;
                        bus.error     <= |stg_err;
                        bus.valid     <= 1'b1;
                        mask          <= cap_mask;
                    end else begin
                        mask <= mask | cap_mask;
                    end
                end
                PRESENT: begin
                    state <= COLLECT;
                    mask  <= mask | cap_mask;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: scans, dwell filtering, error/blank decode,
// illegal anodes, enable flush and asynchronous reset.
module tb_seven_segment_reader;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;

    always #5 clk = ~clk;

    seven_segment_reader_if #(.DIGITS(4)) bus ();

    seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.valid === 1'b1) vcount++;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'b1000000;
            4'h1: seg_of = 7'b1111001;
            4'h2: seg_of = 7'b0100100;
            4'h3: seg_of = 7'b0110000;
            4'h4: seg_of = 7'b0011001;
            4'h5: seg_of = 7'b0010010;
            4'h6: seg_of = 7'b0000010;
            4'h7: seg_of = 7'b1111000;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0011000;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b0000011;
            4'hC: seg_of = 7'b1000110;
            4'hD: seg_of = 7'b0100001;
            4'hE: seg_of = 7'b0000110;
            default: seg_of = 7'b0001110;
        endcase
    endfunction

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_n  = an;
        bus.seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        show(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int d = 0; d < 4; d++) show(~(4'b0001 << d), seg_of(v[4*d +: 4]), 6);
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        bus.an_n   = 4'hF;
        bus.seg_n  = 7'h7F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.value !== 16'h0) begin errors++; $display("FAIL reset_value got %h expected 0000", bus.value); end
        checks++;
        if (bus.blank !== 4'h0 || bus.digit_err !== 4'h0) begin
            errors++; $display("FAIL reset_flags blank=%b digit_err=%b expected 0000/0000", bus.blank, bus.digit_err);
        end
        checks++;
        if (bus.error !== 1'b0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL reset_error_valid error=%b valid=%b expected 0/0", bus.error, bus.valid);
        end
    endtask

    task automatic test_scan();
        int v0;
        reset_dut();
        v0 = vcount;
        show(4'b1110, seg_of(4'h4), 6);
        show(4'b1101, seg_of(4'h3), 6);
        show(4'b1011, seg_of(4'h2), 6);
        bus.an_n  = 4'b0111;
        bus.seg_n = seg_of(4'h1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid !== (i == 5)) begin
                errors++; $display("FAIL scan_latency cycle %0d valid got %b expected %b", i, bus.valid, (i == 5));
            end
        end
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL scan_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'h1234) begin errors++; $display("FAIL scan_value got %h expected 1234", bus.value); end
        checks++;
        if (bus.blank !== 4'h0 || bus.digit_err !== 4'h0 || bus.error !== 1'b0) begin
            errors++; $display("FAIL scan_flags blank=%b digit_err=%b error=%b expected 0000/0000/0", bus.blank, bus.digit_err, bus.error);
        end
    endtask

    task automatic test_short_dwell();
        int v0;
        reset_dut();
        v0 = vcount;
        show(4'b1110, seg_of(4'h4), 6);
        show(4'b1101, seg_of(4'h3), 6);
        show(4'b1011, seg_of(4'h2), 3);
        show(4'b0111, seg_of(4'h1), 6);
        idle(3);
        checks++;
        if (vcount != v0) begin errors++; $display("FAIL short_dwell_pulses got %0d expected 0", vcount - v0); end
        v0 = vcount;
        scan(16'h1234);
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL short_rescan_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'h1234) begin errors++; $display("FAIL short_rescan_value got %h expected 1234", bus.value); end
    endtask

    task automatic test_err_blank();
        int v0;
        reset_dut();
        v0 = vcount;
        show(4'b1110, seg_of(4'hA), 6);
        show(4'b1101, 7'b1010101, 6);
        show(4'b1011, seg_of(4'hF), 6);
        show(4'b0111, 7'b1111111, 6);
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL errblank_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'h0F0A) begin errors++; $display("FAIL errblank_value got %h expected 0f0a", bus.value); end
        checks++;
        if (bus.digit_err !== 4'b0010) begin errors++; $display("FAIL errblank_digit_err got %b expected 0010", bus.digit_err); end
        checks++;
        if (bus.blank !== 4'b1000) begin errors++; $display("FAIL errblank_blank got %b expected 1000", bus.blank); end
        checks++;
        if (bus.error !== 1'b1) begin errors++; $display("FAIL errblank_error got %b expected 1", bus.error); end
    endtask

    task automatic test_illegal();
        int v0;
        reset_dut();
        v0 = vcount;
        show(4'b1100, seg_of(4'h8), 10);
        checks++;
        if (vcount != v0 || bus.value !== 16'h0) begin
            errors++; $display("FAIL illegal_window pulses=%0d value=%h expected 0/0000", vcount - v0, bus.value);
        end
        scan(16'h8765);
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL illegal_after_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'h8765) begin errors++; $display("FAIL illegal_after_value got %h expected 8765", bus.value); end
    endtask

    task automatic test_enable_drop();
        int v0;
        reset_dut();
        scan(16'h1234);
        idle(2);
        v0 = vcount;
        show(4'b1110, seg_of(4'h9), 6);
        show(4'b1101, seg_of(4'hB), 6);
        show(4'b1011, seg_of(4'hC), 6);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        show(4'b0111, seg_of(4'hD), 6);
        idle(3);
        checks++;
        if (vcount != v0) begin errors++; $display("FAIL enable_flush_pulses got %0d expected 0", vcount - v0); end
        checks++;
        if (bus.value !== 16'h1234) begin errors++; $display("FAIL enable_hold_value got %h expected 1234", bus.value); end
        scan(16'hDCB9);
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL enable_rescan_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'hDCB9) begin errors++; $display("FAIL enable_rescan_value got %h expected dcb9", bus.value); end
    endtask

    task automatic test_async_reset();
        int v0;
        reset_dut();
        show(4'b1110, seg_of(4'h5), 6);
        show(4'b1101, 7'b1010101, 6);
        show(4'b1011, seg_of(4'hA), 6);
        show(4'b0111, seg_of(4'h3), 6);
        idle(3);
        checks++;
        if (bus.value !== 16'h3A05 || bus.error !== 1'b1) begin
            errors++; $display("FAIL areset_preframe value=%h error=%b expected 3a05/1", bus.value, bus.error);
        end
        show(4'b1110, seg_of(4'hE), 6);
        show(4'b1101, seg_of(4'h0), 6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.value !== 16'h0 || bus.error !== 1'b0 || bus.digit_err !== 4'h0 || bus.blank !== 4'h0) begin
            errors++; $display("FAIL areset_immediate value=%h error=%b digit_err=%b blank=%b expected all zero",
                               bus.value, bus.error, bus.digit_err, bus.blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vcount;
        scan(16'h2E03);
        idle(3);
        checks++;
        if (vcount - v0 != 1) begin errors++; $display("FAIL areset_after_pulses got %0d expected 1", vcount - v0); end
        checks++;
        if (bus.value !== 16'h2E03 || bus.error !== 1'b0) begin
            errors++; $display("FAIL areset_after_value value=%h error=%b expected 2e03/0", bus.value, bus.error);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        reset_dut();
        v0 = vcount;
        scan(16'h1234);
        scan(16'hCDEF);
        idle(3);
        checks++;
        if (vcount - v0 != 2) begin errors++; $display("FAIL b2b_pulses got %0d expected 2", vcount - v0); end
        checks++;
        if (bus.value !== 16'hCDEF) begin errors++; $display("FAIL b2b_value got %h expected cdef", bus.value); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_short_dwell();
        test_err_blank();
        test_illegal();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
